// File: rtl/wx_stream_driver_if.sv
// wx_stream_driver_if: bundle of the sample input, frame control and per-lane
// cell outputs of the weight-extraction stream driver.
// Handshake: a sample pair transfers on a clock edge where in_valid && in_ready;
// in_ready is !full and never depends on in_valid, and in_valid may be raised or
// dropped at any time.
// slave is the driver's own view; master is the view of whoever feeds it and
// observes the cell outputs.
interface wx_stream_driver_if #(
    parameter int DATA_LENGTH = 8,
    parameter int N           = 4
);
    logic                     in_valid;
    logic                     in_ready;
    logic [N*DATA_LENGTH-1:0] in_a;
    logic [DATA_LENGTH-1:0]   in_b;
    logic                     start;
    logic [15:0]              frame_len;
    logic                     busy;
    logic                     cell_clr;
    logic [N*DATA_LENGTH-1:0] ai_out;
    logic [N*DATA_LENGTH-1:0] bi_out;
    logic [N-1:0]             start1_out;
    logic [N-1:0]             start2_out;
    logic                     frame_done;
    logic [1:0]               dbg_state;

    modport master (
        output in_valid, in_a, in_b, start, frame_len,
        input  in_ready, busy, cell_clr, ai_out, bi_out,
               start1_out, start2_out, frame_done, dbg_state
    );

    modport slave (
        input  in_valid, in_a, in_b, start, frame_len,
        output in_ready, busy, cell_clr, ai_out, bi_out,
               start1_out, start2_out, frame_done, dbg_state
    );
endinterface

// File: rtl/wx_stream_driver.sv
// wx_stream_driver: buffers (a-vector, b) sample pairs in a FIFO and replays
// one frame of them onto N weight-extraction cells, with a per-frame cell
// clear and a completion pulse.
// Optional feature macro WX_DRV_SKEW_EN: lane k is delayed k extra cycles so
// cell k sees each sample k cycles after cell 0; without it every lane strobes
// one cycle after the pop.
// FSM: IDLE accepts start, RUN pops one entry per non-empty cycle until the
// frame count is exhausted, DRAIN waits for the skew pipe to empty.
// The FSM state is visible on dbg_state (0 IDLE, 1 RUN, 2 DRAIN).
module wx_stream_driver #(
    parameter int DATA_LENGTH = 8,
    parameter int N           = 4,
    parameter int DEPTH       = 8
) (
    input logic               clk,
    input logic               rst,
    wx_stream_driver_if.slave io_bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int VW = N * DATA_LENGTH;
`ifdef WX_DRV_SKEW_EN
    localparam bit SKEW = 1'b1;
`else
    localparam bit SKEW = 1'b0;
`endif
    // Number of register stages on the longest lane.
    localparam int NSTG = SKEW ? N : 1;
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};
    localparam logic [15:0] REM_ONE = 16'd1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t                 r_state;
    state_t                 w_state_next;
    logic [VW-1:0]          r_mem_a [DEPTH];
    logic [DATA_LENGTH-1:0] r_mem_b [DEPTH];
    logic [AW:0]            r_wr_ptr;
    logic [AW:0]            r_rd_ptr;
    logic [AW-1:0]          w_rd_idx;
    logic                   w_full;
    logic                   w_empty;
    logic                   w_push;
    logic                   w_pop;
    logic                   w_load;
    logic                   w_clr_set;
    logic                   w_done_set;
    logic                   w_busy;
    logic [15:0]            r_remaining;
    logic                   r_cell_clr;
    logic                   r_frame_done;
    logic [NSTG-1:0]        r_vld;
    logic [DATA_LENGTH-1:0] r_pb [NSTG];
    logic                   w_pipe_clearing;

    // Extra pointer bit tells full from empty when the indices match.
    assign w_rd_idx = r_rd_ptr[AW-1:0];
    assign w_empty  = (r_wr_ptr == r_rd_ptr);
    assign w_full   = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                      (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_push   = io_bus.in_valid && !w_full;

    // FIFO pointers; reset flushes any queued samples.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
        end
    end

    // FIFO storage, written on every accepted sample.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_a[r_wr_ptr[AW-1:0]] <= io_bus.in_a;
            r_mem_b[r_wr_ptr[AW-1:0]] <= io_bus.in_b;
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_next;
    end

    // FSM next state; a zero-length start stays in IDLE.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (io_bus.start && (io_bus.frame_len != 16'd0)) w_state_next = S_RUN;
            S_RUN:   if (w_pop && (r_remaining == REM_ONE)) w_state_next = S_DRAIN;
            S_DRAIN: if (w_pipe_clearing) w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    // FSM outputs: pop requests, frame load and the one-cycle pulse requests.
    always_comb begin
        w_pop      = 1'b0;
        w_load     = 1'b0;
        w_clr_set  = 1'b0;
        w_done_set = 1'b0;
        w_busy     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (io_bus.start) begin
                    w_load = 1'b1;
                    if (io_bus.frame_len == 16'd0) w_done_set = 1'b1;
                    else                           w_clr_set  = 1'b1;
                end
            end
            S_RUN: begin
                w_busy = 1'b1;
                w_pop  = !w_empty;
            end
            S_DRAIN: begin
                w_busy     = 1'b1;
                w_done_set = w_pipe_clearing;
            end
            default: ;
        endcase
    end

    // Frame counter and registered clear/done pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_remaining  <= '0;
            r_cell_clr   <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            r_cell_clr   <= w_clr_set;
            r_frame_done <= w_done_set;
            if (w_load)     r_remaining <= io_bus.frame_len;
            else if (w_pop) r_remaining <= r_remaining - REM_ONE;
        end
    end

    // Valid bit shift chain shared by all lanes; lane k taps stage k.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_vld <= '0;
        end else begin
            r_vld[0] <= w_pop;
            for (int s = 1; s < NSTG; s++) r_vld[s] <= r_vld[s-1];
        end
    end

    // Shared b chain; data only moves with a valid entry so outputs hold.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int s = 0; s < NSTG; s++) r_pb[s] <= '0;
        end else begin
            if (w_pop) r_pb[0] <= r_mem_b[w_rd_idx];
            for (int s = 1; s < NSTG; s++) begin
                if (r_vld[s-1]) r_pb[s] <= r_pb[s-1];
            end
        end
    end

    // The pipe is empty after this edge when only final-stage entries remain.
    always_comb begin
        w_pipe_clearing = 1'b1;
        for (int s = 0; s < NSTG - 1; s++) begin
            if (r_vld[s]) w_pipe_clearing = 1'b0;
        end
    end

    for (genvar k = 0; k < N; k++) begin : g_lane
        localparam int D = SKEW ? k + 1 : 1;
        logic [DATA_LENGTH-1:0] r_pa [D];

        // Per-lane a chain of D stages, advancing with the valid chain.
        always_ff @(posedge clk) begin
            if (rst) begin
                for (int s = 0; s < D; s++) r_pa[s] <= '0;
            end else begin
                if (w_pop) r_pa[0] <= r_mem_a[w_rd_idx][k*DATA_LENGTH +: DATA_LENGTH];
                for (int s = 1; s < D; s++) begin
                    if (r_vld[s-1]) r_pa[s] <= r_pa[s-1];
                end
            end
        end

        assign io_bus.ai_out[k*DATA_LENGTH +: DATA_LENGTH] = r_pa[D-1];
        assign io_bus.bi_out[k*DATA_LENGTH +: DATA_LENGTH] = r_pb[D-1];
        assign io_bus.start1_out[k]                        = r_vld[D-1];
        assign io_bus.start2_out[k]                        = r_vld[D-1];
    end

    assign io_bus.in_ready   = !w_full;
    assign io_bus.busy       = w_busy;
    assign io_bus.cell_clr   = r_cell_clr;
    assign io_bus.frame_done = r_frame_done;
    assign io_bus.dbg_state  = r_state;
endmodule

// File: tb/tb_wx_stream_driver.sv
// tb_wx_stream_driver: directed bench for wx_stream_driver. A sample-level
// model (FIFO as a queue, frame bookkeeping, lane events scheduled by cycle)
// predicts every output each cycle; literal expectations pin the model.
module tb_wx_stream_driver;
    localparam int DL    = 8;
    localparam int N     = 4;
    localparam int DEPTH = 8;
    localparam int AW    = N * DL;
`ifdef WX_DRV_SKEW_EN
    localparam bit SKEW = 1'b1;
`else
    localparam bit SKEW = 1'b0;
`endif
    // Cycles from the last pop to frame_done.
    localparam int LAT = SKEW ? N + 1 : 2;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;

    wx_stream_driver_if #(.DATA_LENGTH(DL), .N(N)) bus ();

    wx_stream_driver #(.DATA_LENGTH(DL), .N(N), .DEPTH(DEPTH)) dut (
        .clk    (clk),
        .rst    (rst),
        .io_bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // ---------------- model ----------------
    typedef struct {
        int            at;
        int            lane;
        logic [DL-1:0] a;
        logic [DL-1:0] b;
    } ev_t;

    ev_t           ev_q[$];
    logic [AW-1:0] mq_a[$];
    logic [DL-1:0] mq_b[$];
    int            m_state   = 0;  // 0 idle, 1 run, 2 drain
    int            m_rem     = 0;
    int            m_done_at = 0;
    bit            m_valid   = 1'b0;
    logic          e_in_ready, e_busy, e_clr, e_done;
    logic [N-1:0]  e_stb;
    logic [AW-1:0] e_ai, e_bi;

    // Predict the outputs of cycle cyc+1 from the inputs of cycle cyc.
    task automatic model_step();
        ev_t           keep[$];
        bit            do_push;
        bit            do_pop;
        logic [AW-1:0] a;
        logic [DL-1:0] b;
        if (rst) begin
            mq_a.delete();
            mq_b.delete();
            ev_q.delete();
            m_state    = 0;
            m_rem      = 0;
            e_in_ready = 1'b1;
            e_busy     = 1'b0;
            e_clr      = 1'b0;
            e_done     = 1'b0;
            e_stb      = '0;
            e_ai       = '0;
            e_bi       = '0;
        end else begin
            do_push = bus.in_valid && (mq_a.size() < DEPTH);
            do_pop  = (m_state == 1) && (mq_a.size() > 0);
            e_clr   = 1'b0;
            e_done  = 1'b0;
            if (do_pop) begin
                a = mq_a.pop_front();
                b = mq_b.pop_front();
                for (int k = 0; k < N; k++)
                    ev_q.push_back('{cyc + 1 + (SKEW ? k : 0), k, a[k*DL +: DL], b});
                m_rem--;
                if (m_rem == 0) begin
                    m_state   = 2;
                    m_done_at = cyc + LAT;
                end
            end else if (m_state == 0 && bus.start) begin
                if (bus.frame_len == 16'd0) e_done = 1'b1;
                else begin
                    e_clr   = 1'b1;
                    m_state = 1;
                    m_rem   = int'(bus.frame_len);
                end
            end else if (m_state == 2 && cyc + 1 == m_done_at) begin
                e_done  = 1'b1;
                m_state = 0;
            end
            if (do_push) begin
                mq_a.push_back(bus.in_a);
                mq_b.push_back(bus.in_b);
            end
            e_in_ready = mq_a.size() < DEPTH;
            e_busy     = m_state != 0;
            e_stb      = '0;
            foreach (ev_q[i]) begin
                if (ev_q[i].at == cyc + 1) begin
                    e_stb[ev_q[i].lane]          = 1'b1;
                    e_ai[ev_q[i].lane*DL +: DL]  = ev_q[i].a;
                    e_bi[ev_q[i].lane*DL +: DL]  = ev_q[i].b;
                end else begin
                    keep.push_back(ev_q[i]);
                end
            end
            ev_q = keep;
        end
    endtask

    // Compare process: check the current cycle, then advance the model.
    always @(negedge clk) begin
        if (m_valid) begin
            chk("in_ready",   bus.in_ready,   e_in_ready);
            chk("busy",       bus.busy,       e_busy);
            chk("cell_clr",   bus.cell_clr,   e_clr);
            chk("frame_done", bus.frame_done, e_done);
            chk("start1_out", bus.start1_out, e_stb);
            chk("start2_out", bus.start2_out, e_stb);
            chk("ai_out",     bus.ai_out,     e_ai);
            chk("bi_out",     bus.bi_out,     e_bi);
        end
        model_step();
        m_valid = 1'b1;
    end

    // Lane-2 scoreboard with hand-computed values for the first frame.
    logic [DL-1:0] exp_q[$];
    logic [DL-1:0] exp_b_q[$];
    bit            mon_en      = 1'b0;
    int            lane2_first = -1;

    always @(negedge clk) begin
        if (mon_en && bus.start1_out[2]) begin
            if (lane2_first < 0) lane2_first = cyc;
            if (exp_q.size() == 0) begin
                n_checks++;
                $display("FAIL lane2_strobe: unexpected strobe at cycle %0d, expected none", cyc);
            end else begin
                chk("lane2_a", bus.ai_out[2*DL +: DL], exp_q.pop_front());
                chk("lane2_b", bus.bi_out[2*DL +: DL], exp_b_q.pop_front());
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_pair(input logic [AW-1:0] a, input logic [DL-1:0] b);
        bit acc = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_a     = a;
        bus.in_b     = b;
        for (int i = 0; i < 50 && !acc; i++) begin
            acc = bus.in_ready;
            tick();
        end
        bus.in_valid = 1'b0;
        if (!acc) begin
            n_checks++;
            $display("FAIL push_timeout: in_ready stayed 0 for 50 cycles, expected 1");
        end
    endtask

    task automatic pulse_start(input logic [15:0] len);
        bus.start     = 1'b1;
        bus.frame_len = len;
        tick();
        bus.start     = 1'b0;
    endtask

    task automatic wait_done(input int budget, output int at);
        at = -1;
        for (int i = 0; i < budget; i++) begin
            if (bus.frame_done) begin
                at = cyc;
                break;
            end
            tick();
        end
        if (at < 0) begin
            n_checks++;
            $display("FAIL wait_done: frame_done 0 for %0d cycles, expected 1", budget);
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int t0;
        int d;
        bit seen;

        rst           = 1'b1;
        bus.in_valid  = 1'b1;
        bus.in_a      = 32'hDEAD_BEEF;
        bus.in_b      = 8'h77;
        bus.start     = 1'b0;
        bus.frame_len = 16'd0;
        exp_q   = '{8'd3, 8'd8, 8'd13};
        exp_b_q = '{8'd5, 8'd10, 8'd15};

        // Reset held 3 cycles while a sample is offered.
        repeat (3) tick();
        rst          = 1'b0;
        bus.in_valid = 1'b0;
        chk("reset_in_ready", bus.in_ready, 1);
        chk("reset_strobes", bus.start1_out, 0);
        chk("reset_busy", bus.busy, 0);
        tick();

        // Frame of 3.
        push_pair({8'd4, 8'd3, 8'd2, 8'd1}, 8'd5);
        push_pair({8'd9, 8'd8, 8'd7, 8'd6}, 8'd10);
        push_pair({8'd14, 8'd13, 8'd12, 8'd11}, 8'd15);
        mon_en = 1'b1;
        t0 = cyc;
        pulse_start(16'd3);
        chk("frame3_cell_clr", bus.cell_clr, 1);
        wait_done(100, d);
        chk("frame3_done_latency", d - t0, 3 + LAT);
        tick();
        mon_en = 1'b0;
        chk("frame3_lane2_count", exp_q.size(), 0);
        chk("frame3_lane2_first", lane2_first - t0, SKEW ? 4 : 2);

        // Underflow: two queued, two more arrive late.
        push_pair({8'h24, 8'h23, 8'h22, 8'h21}, 8'h20);
        push_pair({8'h34, 8'h33, 8'h32, 8'h31}, 8'h30);
        t0 = cyc;
        pulse_start(16'd4);
        repeat (6) tick();
        chk("underflow_busy", bus.busy, 1);
        chk("underflow_no_strobe", bus.start1_out, 0);
        push_pair({8'h44, 8'h43, 8'h42, 8'h41}, 8'h40);
        push_pair({8'h54, 8'h53, 8'h52, 8'h51}, 8'h50);
        wait_done(100, d);
        chk("underflow_done_latency", d - t0, 9 + LAT);
        tick();

        // Full FIFO while idle; the ninth offer waits.
        for (int i = 0; i < DEPTH; i++)
            push_pair({4{8'(8'h60 + i)}}, 8'(8'h90 + i));
        chk("full_in_ready", bus.in_ready, 0);
        bus.in_valid = 1'b1;
        bus.in_a     = 32'hA5A5_5A5A;
        bus.in_b     = 8'hEE;
        tick();
        tick();
        chk("full_held_ready", bus.in_ready, 0);
        bus.start     = 1'b1;
        bus.frame_len = 16'd9;
        t0 = cyc;
        tick();
        bus.start = 1'b0;
        chk("full_ready_first_pop", bus.in_ready, 0);
        tick();
        chk("full_ready_after_pop", bus.in_ready, 1);
        tick();
        bus.in_valid = 1'b0;
        wait_done(100, d);
        chk("full_done_latency", d - t0, 9 + LAT);
        tick();

        // Zero-length frame.
        pulse_start(16'd0);
        chk("len0_done", bus.frame_done, 1);
        chk("len0_no_clr", bus.cell_clr, 0);
        chk("len0_busy", bus.busy, 0);
        tick();
        chk("len0_done_once", bus.frame_done, 0);

        // Start while busy is ignored.
        push_pair({8'h74, 8'h73, 8'h72, 8'h71}, 8'h70);
        push_pair({8'h84, 8'h83, 8'h82, 8'h81}, 8'h80);
        pulse_start(16'd2);
        pulse_start(16'd5);
        wait_done(100, d);
        repeat (3) tick();
        chk("busy_start_ignored", bus.busy, 0);

        // Back-to-back frames: start in the frame_done cycle.
        push_pair({8'hB4, 8'hB3, 8'hB2, 8'hB1}, 8'hB0);
        push_pair({8'hC4, 8'hC3, 8'hC2, 8'hC1}, 8'hC0);
        pulse_start(16'd1);
        wait_done(100, d);
        pulse_start(16'd1);
        chk("b2b_cell_clr", bus.cell_clr, 1);
        chk("b2b_busy", bus.busy, 1);
        wait_done(100, d);
        tick();

        // Reset in DRAIN: no completion, queued sample flushed.
        push_pair({8'hD4, 8'hD3, 8'hD2, 8'hD1}, 8'hD0);
        push_pair({8'hE4, 8'hE3, 8'hE2, 8'hE1}, 8'hE0);
        pulse_start(16'd1);
        tick();
        chk("drain_busy", bus.busy, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        seen = 1'b0;
        repeat (10) begin
            if (bus.frame_done || bus.cell_clr) seen = 1'b1;
            tick();
        end
        chk("rst_no_done_no_clr", seen, 0);
        push_pair({8'hF4, 8'hF3, 8'hF2, 8'hF1}, 8'hF0);
        pulse_start(16'd1);
        wait_done(100, d);
        repeat (3) tick();
        chk("final_idle", bus.busy, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/wx_stream_driver.md
# wx_stream_driver

Transmit-side sequencer for the QRD-RLS weight-extraction row. It buffers incoming (a-vector, b) sample pairs in a FIFO and replays one frame of them onto N weight-extraction cells. Each lane gets `ai_in`/`bi_in` and the `start_input1`/`start_input2` strobes with systolic skew, so cell k sees a sample k cycles after cell 0. It also issues a per-frame cell clear and a completion pulse. It sits between the back-substitution front end and the weight-extraction cell chain.

## Interface
- `DATA_LENGTH`, 8: width of each a/b word.
- `N`, 4: number of downstream cells (lanes), ≥1.
- `DEPTH`, 8: FIFO entries, power of 2, ≥2.
- `clk` in 1: clock.
- `rst` in 1: reset, synchronous, active-high.
- `in_valid` in 1: sample pair offered.
- `in_ready` out 1: FIFO can accept; equals !full.
- `in_a` in N*DATA_LENGTH: a-vector; lane k is bits [k*DATA_LENGTH +: DATA_LENGTH].
- `in_b` in DATA_LENGTH: b value, shared by all lanes.
- `start` in 1: frame start pulse.
- `frame_len` in 16: number of samples in the frame; sampled when `start` is accepted.
- `busy` out 1: high in RUN and DRAIN.
- `cell_clr` out 1: one-cycle clear to the cells.
- `ai_out` out N*DATA_LENGTH: per-lane a value for the cells.
- `bi_out` out N*DATA_LENGTH: per-lane b value, skewed with its lane.
- `start1_out` out N: per-lane `start_input1`.
- `start2_out` out N: per-lane `start_input2`.
- `frame_done` out 1: one-cycle pulse when the frame has fully drained.

## Operation
- FIFO push happens when `in_valid && in_ready`. There is no bypass: a word pushed in cycle t can be popped from t+1.
- The FSM has three states:
  - IDLE: `start` is accepted. It latches `frame_len` into `remaining` and asserts `cell_clr` for the next cycle.
    - If `frame_len` == 0, the block pulses `frame_done` the next cycle and stays in IDLE.
    - Otherwise it moves to RUN.
  - RUN: each cycle with FIFO not empty, the block pops one entry, issues it to lane 0 of the skew pipe, and decrements `remaining`.
    - FIFO empty gives a bubble: no strobes, `remaining` unchanged.
    - The pop that takes `remaining` to 0 moves the FSM to DRAIN.
  - DRAIN: waits until the skew pipe holds no valid entry, pulses `frame_done`, then returns to IDLE.
- Skew pipe: lane k carries a, b, and a valid bit, registered through k+1 stages.
  - `start1_out[k]` = `start2_out[k]` = lane-k valid.
  - `ai_out`/`bi_out` hold their last issued value when valid is low.
- `start` while `busy` is ignored.
- FIFO entries beyond `frame_len` stay queued for the next frame.
- Pushes are allowed in every state.

## Timing
- Reset values:
  - All outputs 0 except `in_ready`, which is 1.
  - FIFO empty, state IDLE, skew pipe cleared.
- `start` accepted at cycle t:
  - `cell_clr` = 1 at t+1.
  - First pop no earlier than t+1.
- Pop at cycle p: lane k strobe and data are visible at p+1+k.
- Last pop at cycle L: `frame_done` at L+N+1 with skew, L+2 without.
- Back-to-back frames: `start` in the same cycle `frame_done` is high is accepted, because the FSM is already in IDLE in that cycle.
- `rst` mid-frame:
  - Next cycle is IDLE with the FIFO flushed.
  - All strobes are 0.
  - No `frame_done` or `cell_clr` is issued.
- Full FIFO: `in_ready` = 0. A pop in the same cycle raises `in_ready` at the next cycle.

## Configuration
- `WX_DRV_SKEW_EN` defined: lane k is delayed k extra cycles, as described above.
- Not defined:
  - All lanes use a single register stage; every lane strobes at p+1.
  - The DRAIN wait is one cycle.

## Test plan
- Reset: hold `rst` 3 cycles with `in_valid` = 1.
  - Required: no push, `in_ready` = 1 after release, all strobes 0.
- Frame of 3, N=4, skew on:
  - Push (a={1,2,3,4}, b=5), then (6..9, 10), then (11..14, 15); pulse `start` with `frame_len`=3.
  - Required: `cell_clr` at t+1.
  - Required: lane 2 strobes at pops+3 carrying a=3,8,13 with b=5,10,15.
  - Required: `frame_done` exactly N+1 cycles after the last pop.
- Underflow:
  - `start` with `frame_len`=4 and only 2 entries queued; push the rest 5 cycles later.
  - Required: bubbles with no strobes, `remaining` held, frame completes after the late pushes.
- Full FIFO:
  - Push DEPTH=8 entries while idle.
  - Required: `in_ready` = 0; the 9th offer is held, not lost.
  - Required: after `start`, `in_ready` rises the cycle after the first pop.
- Corner cases:
  - `frame_len`=0: `frame_done` at t+1, no `cell_clr`.
  - `start` while busy: ignored.
  - `rst` asserted mid-DRAIN: no `frame_done`.
- `WX_DRV_SKEW_EN` undefined: all 4 lanes strobe in the same cycle; `frame_done` at L+2.
